// File: rtl/frame_fill_pkg.sv
// Shared types for the frame fill engine: command modes and controller states.
package frame_fill_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR     = 2'd0,
    MODE_CHECKER   = 2'd1,
    MODE_RECT      = 2'd2,
    MODE_END_FRAME = 2'd3
  } fill_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fill_state_t;

endpackage

// File: rtl/frame_fill_engine_scanner.sv
// Clipped-rectangle raster counter: walks x fastest, then y, keeping a row base
// so the linear address never needs a multiplier.
module fill_scanner #(
  parameter int H      = 640,
  parameter int V      = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [X_W-1:0]    i_x0,
  input  logic [X_W-1:0]    i_x1,
  input  logic [Y_W-1:0]    i_y0,
  input  logic [Y_W-1:0]    i_y1,
  output logic [X_W-1:0]    o_x,
  output logic [Y_W-1:0]    o_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [X_W-1:0] LP_X_MAX = X_W'(H - 1);
  localparam logic [Y_W-1:0] LP_Y_MAX = Y_W'(V - 1);

  logic [X_W-1:0]    r_x, r_x_start, r_x_end;
  logic [Y_W-1:0]    r_y, r_y_end;
  logic [ADDR_W-1:0] r_row_base;

  // y*H as a sum of shifted copies of the constant H
  function automatic logic [ADDR_W-1:0] row_offset(input logic [Y_W-1:0] y_in);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < Y_W; i++)
      if (y_in[i]) acc = acc + ADDR_W'(H << i);
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_x_start  <= '0;
      r_x_end    <= '0;
      r_y_end    <= '0;
      r_row_base <= '0;
    end else if (ce) begin
      if (i_start) begin
        r_x        <= i_x0;
        r_y        <= i_y0;
        r_x_start  <= i_x0;
        r_x_end    <= (i_x1 > LP_X_MAX) ? LP_X_MAX : i_x1;
        r_y_end    <= (i_y1 > LP_Y_MAX) ? LP_Y_MAX : i_y1;
        r_row_base <= row_offset(i_y0);
      end else if (i_step) begin
        if (r_x == r_x_end) begin
          r_x        <= r_x_start;
          r_y        <= r_y + 1'b1;
          r_row_base <= r_row_base + ADDR_W'(H);
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_row_base + ADDR_W'(r_x);
  assign o_last = (r_x == r_x_end) && (r_y == r_y_end);

endmodule

// File: rtl/frame_fill_engine.sv
// Drawing engine: accepts one command at a time, rasterises it into pixel writes,
// and parks on END_FRAME until the display swaps buffers.
//   state        | meaning
//   ST_IDLE      | cmd_ready=1, waiting for a command
//   ST_FILL      | one pixel write per ce cycle over the scan region
//   ST_WAIT_SWAP | frame closed, waiting for swap
module frame_fill_engine #(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  parameter  int PIXEL_WIDTH       = 1,
  parameter  int CELL_LOG2         = 0,
  localparam int X_W    = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_W    = $clog2(VER_ACTIVE_PIXELS),
  localparam int ADDR_W = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [X_W-1:0]         cmd_x0,
  input  logic [X_W-1:0]         cmd_x1,
  input  logic [Y_W-1:0]         cmd_y0,
  input  logic [Y_W-1:0]         cmd_y1,
  input  logic [PIXEL_WIDTH-1:0] cmd_color0,
  input  logic [PIXEL_WIDTH-1:0] cmd_color1,
  input  logic                   swap,
  output logic                   frame_done,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [PIXEL_WIDTH-1:0] wr_data
);
  import frame_fill_pkg::*;

  localparam logic [X_W:0] LP_H_EXT = (X_W + 1)'(HOR_ACTIVE_PIXELS);
  localparam logic [Y_W:0] LP_V_EXT = (Y_W + 1)'(VER_ACTIVE_PIXELS);

  fill_state_t r_state, w_next_state;
  fill_mode_t  r_mode, w_cmd_mode;

  logic [PIXEL_WIDTH-1:0] r_color0, r_color1, r_wr_data, w_pixel;
  logic [ADDR_W-1:0]      r_wr_addr, w_addr;
  logic                   r_wr_en, r_frame_done;
  logic                   w_accept, w_start, w_write, w_done;
  logic                   w_rect_empty, w_last, w_cell_odd;
  logic [X_W-1:0]         w_sx0, w_sx1, w_x;
  logic [Y_W-1:0]         w_sy0, w_sy1, w_y;

  assign w_cmd_mode = fill_mode_t'(cmd_mode);

  // Emptiness uses the unclipped bounds; clipping only trims the far edges
  assign w_rect_empty = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) ||
                        ({1'b0, cmd_x0} >= LP_H_EXT) || ({1'b0, cmd_y0} >= LP_V_EXT);

  assign w_sx0 = (w_cmd_mode == MODE_RECT) ? cmd_x0 : '0;
  assign w_sx1 = (w_cmd_mode == MODE_RECT) ? cmd_x1 : X_W'(HOR_ACTIVE_PIXELS - 1);
  assign w_sy0 = (w_cmd_mode == MODE_RECT) ? cmd_y0 : '0;
  assign w_sy1 = (w_cmd_mode == MODE_RECT) ? cmd_y1 : Y_W'(VER_ACTIVE_PIXELS - 1);

  fill_scanner #(
    .H      (HOR_ACTIVE_PIXELS),
    .V      (VER_ACTIVE_PIXELS),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_scanner (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .i_start (w_start),
    .i_step  (w_write),
    .i_x0    (w_sx0),
    .i_x1    (w_sx1),
    .i_y0    (w_sy0),
    .i_y1    (w_sy1),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  assign w_cell_odd = (|((w_x >> CELL_LOG2) & X_W'(1))) ^ (|((w_y >> CELL_LOG2) & Y_W'(1)));
  assign w_pixel    = (r_mode == MODE_CHECKER && w_cell_odd) ? r_color1 : r_color0;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_write      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          case (w_cmd_mode)
            MODE_END_FRAME: w_next_state = ST_WAIT_SWAP;
            MODE_RECT: begin
              if (!w_rect_empty) begin
                w_start      = 1'b1;
                w_next_state = ST_FILL;
              end
            end
            default: begin
              w_start      = 1'b1;
              w_next_state = ST_FILL;
            end
          endcase
        end
      end
      ST_FILL: begin
        w_write = 1'b1;
        if (w_last) w_next_state = ST_IDLE;
      end
      ST_WAIT_SWAP: begin
        if (swap) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_CLEAR;
      r_color0     <= '0;
      r_color1     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
    end else if (ce) begin
      r_state      <= w_next_state;
      r_wr_en      <= w_write;
      r_frame_done <= w_done;
      if (w_accept) begin
        r_mode   <= w_cmd_mode;
        r_color0 <= cmd_color0;
        r_color1 <= cmd_color1;
      end
      if (w_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pixel;
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign frame_done = r_frame_done;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_frame_fill_engine.sv
// Bench for frame_fill_engine on a 10x6 screen, 2-bit pixels, 2-pixel checker cells.
module tb_frame_fill_engine;

  localparam int H      = 10;
  localparam int V      = 6;
  localparam int PW     = 2;
  localparam int CL     = 1;
  localparam int X_W    = $clog2(H);
  localparam int Y_W    = $clog2(V);
  localparam int ADDR_W = $clog2(H * V);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = '0;
  logic [X_W-1:0]    cmd_x0 = '0, cmd_x1 = '0;
  logic [Y_W-1:0]    cmd_y0 = '0, cmd_y1 = '0;
  logic [PW-1:0]     cmd_color0 = '0, cmd_color1 = '0;
  logic              swap = 1'b0;
  logic              frame_done, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PW-1:0]     wr_data;

  frame_fill_engine #(
    .HOR_ACTIVE_PIXELS (H),
    .VER_ACTIVE_PIXELS (V),
    .PIXEL_WIDTH       (PW),
    .CELL_LOG2         (CL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_x0     (cmd_x0),
    .cmd_x1     (cmd_x1),
    .cmd_y0     (cmd_y0),
    .cmd_y1     (cmd_y1),
    .cmd_color0 (cmd_color0),
    .cmd_color1 (cmd_color1),
    .swap       (swap),
    .frame_done (frame_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode, x0, x1, y0, y1, c0, c1;
    int cnt, first, last;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  int fd_cnt = 0;

  // Consumer view: a write lands on a clock edge only when ce is high
  always @(negedge clk) begin
    if (rst_n && ce && wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
    end
    if (rst_n && ce && frame_done) fd_cnt++;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic build_expected(input int mode, input int x0, input int x1,
                                input int y0, input int y1, input int c0, input int c1);
    int xs, xe, ys, ye;
    exp_addr.delete();
    exp_data.delete();
    if (mode == 3) return;
    if (mode == 2) begin
      if (x0 > x1 || y0 > y1 || x0 >= H || y0 >= V) return;
      xs = x0; ys = y0;
      xe = (x1 < H - 1) ? x1 : H - 1;
      ye = (y1 < V - 1) ? y1 : V - 1;
    end else begin
      xs = 0; ys = 0; xe = H - 1; ye = V - 1;
    end
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++) begin
        exp_addr.push_back(y * H + x);
        if (mode == 1 && ((((x >> CL) & 1) ^ ((y >> CL) & 1)) != 0)) exp_data.push_back(c1);
        else exp_data.push_back(c0);
      end
  endtask

  task automatic compare_run(input string name);
    int mism;
    mism = 0;
    check($sformatf("%s count", name), got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) mism++;
    check($sformatf("%s pixel errors", name), mism, 0);
  endtask

  task automatic drive_cmd(input int mode, input int x0, input int x1,
                           input int y0, input int y1, input int c0, input int c1);
    cmd_mode   = 2'(mode);
    cmd_x0     = X_W'(x0);
    cmd_x1     = X_W'(x1);
    cmd_y0     = Y_W'(y0);
    cmd_y1     = Y_W'(y1);
    cmd_color0 = PW'(c0);
    cmd_color1 = PW'(c1);
    cmd_valid  = 1'b1;
  endtask

  // Waits for ready, then presents the command for exactly one ce edge
  task automatic issue(input int mode, input int x0, input int x1,
                       input int y0, input int y1, input int c0, input int c1);
    int n;
    n = 0;
    ce = 1'b1;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready before issue", 0, 1);
    drive_cmd(mode, x0, x1, y0, y1, c0, c1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input int mode, input int x0, input int x1,
                         input int y0, input int y1, input int c0, input int c1,
                         input bit rand_ce, output int low_cycles);
    int n;
    got_addr.delete();
    got_data.delete();
    build_expected(mode, x0, x1, y0, y1, c0, c1);
    issue(mode, x0, x1, y0, y1, c0, c1);
    low_cycles = 0;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      low_cycles++;
      if (rand_ce) ce = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s ready after fill", name), int'(cmd_ready), 1);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_run(name);
  endtask

  function automatic int data_at(input int a);
    foreach (got_addr[i]) if (got_addr[i] == a) return got_data[i];
    return -1;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   low, n, hold_err, rdy_err, prev_a, prev_en;
    bit   ce_was;

    vecs[0] = '{0, 0, 0, 0, 0, 2, 0, 60, 0, 59};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 3, 60, 0, 59};
    vecs[2] = '{2, 6, 14, 1, 2, 1, 0, 8, 16, 29};
    vecs[3] = '{2, 5, 3, 0, 3, 1, 0, 0, 0, 0};
    vecs[4] = '{2, 0, 3, 6, 7, 1, 0, 0, 0, 0};
    vecs[5] = '{2, 12, 14, 0, 1, 1, 0, 0, 0, 0};
    vecs[6] = '{2, 3, 3, 2, 7, 3, 0, 4, 23, 53};
    vecs[7] = '{2, 0, 15, 5, 5, 2, 1, 10, 50, 59};
    vecs[8] = '{2, 9, 9, 0, 0, 3, 2, 1, 9, 9};

    // Reset state
    #22;
    check("reset wr_en", int'(wr_en), 0);
    check("reset wr_addr", int'(wr_addr), 0);
    check("reset wr_data", int'(wr_data), 0);
    check("reset frame_done", int'(frame_done), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready after reset", int'(cmd_ready), 1);

    // Table of directed commands
    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].mode, vecs[i].x0, vecs[i].x1, vecs[i].y0,
              vecs[i].y1, vecs[i].c0, vecs[i].c1, 1'b0, low);
      check($sformatf("vec%0d ready-low cycles", i), low, vecs[i].cnt);
      if (vecs[i].cnt > 0) begin
        check($sformatf("vec%0d first addr", i),
              got_addr.size() > 0 ? got_addr[0] : -1, vecs[i].first);
        check($sformatf("vec%0d last addr", i),
              got_addr.size() > 0 ? got_addr[got_addr.size() - 1] : -1, vecs[i].last);
      end
    end

    // Checker cells at selected coordinates
    run_cmd("checker", 1, 0, 0, 0, 0, 0, 3, 1'b0, low);
    check("checker (0,0)", data_at(0 * H + 0), 0);
    check("checker (2,0)", data_at(0 * H + 2), 3);
    check("checker (2,2)", data_at(2 * H + 2), 0);
    check("checker (1,3)", data_at(3 * H + 1), 3);

    // Empty RECT leaves the engine ready; next command accepted on the next edge
    got_addr.delete();
    got_data.delete();
    issue(2, 5, 3, 0, 3, 1, 0);
    check("empty rect ready", int'(cmd_ready), 1);
    check("empty rect wr_en", int'(wr_en), 0);
    build_expected(0, 0, 0, 0, 0, 1, 0);
    drive_cmd(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("clear after empty rect accepted", int'(cmd_ready), 0);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    compare_run("clear after empty rect");

    // swap ignored outside WAIT_SWAP, then END_FRAME with a late swap
    fd_cnt = 0;
    swap = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    swap = 1'b0;
    check("swap ignored in idle", fd_cnt, 0);
    issue(3, 0, 0, 0, 0, 0, 0);
    rdy_err = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cmd_ready || wr_en || frame_done) rdy_err++;
    end
    check("wait_swap ready/wr_en/frame_done low", rdy_err, 0);
    swap = 1'b1;
    @(posedge clk); #1;
    swap = 1'b0;
    check("frame_done on swap", int'(frame_done), 1);
    check("ready after swap", int'(cmd_ready), 1);
    @(posedge clk); #1;
    check("frame_done single pulse", int'(frame_done), 0);
    check("frame_done pulse count", fd_cnt, 1);

    // END_FRAME with swap already high on the edge after accept
    swap = 1'b1;
    issue(3, 0, 0, 0, 0, 0, 0);
    check("end_frame early swap ready low", int'(cmd_ready), 0);
    @(posedge clk); #1;
    swap = 1'b0;
    check("early swap frame_done", int'(frame_done), 1);
    check("early swap ready", int'(cmd_ready), 1);

    // ce toggling during CLEAR: outputs hold while ce is low
    got_addr.delete();
    got_data.delete();
    build_expected(0, 0, 0, 0, 0, 1, 0);
    issue(0, 0, 0, 0, 0, 1, 0);
    hold_err = 0;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      prev_a = int'(wr_addr);
      prev_en = int'(wr_en);
      ce_was = ce;
      @(posedge clk); #1;
      if (!ce_was && (int'(wr_addr) != prev_a || int'(wr_en) != prev_en)) hold_err++;
      ce = ~ce;
      n++;
    end
    check("ce toggle ready after fill", int'(cmd_ready), 1);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_run("ce toggle clear");
    check("ce low hold errors", hold_err, 0);

    // Reset in the middle of a CLEAR
    got_addr.delete();
    got_data.delete();
    issue(0, 0, 0, 0, 0, 2, 0);
    n = 0;
    while (got_addr.size() < 10 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid-clear reached pixel 10", got_addr.size(), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset wr_en", int'(wr_en), 0);
    check("async reset wr_addr", int'(wr_addr), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("ready after mid-fill reset", int'(cmd_ready), 1);
    run_cmd("clear after reset", 0, 0, 0, 0, 0, 3, 0, 1'b0, low);
    check("clear after reset first addr", got_addr.size() > 0 ? got_addr[0] : -1, 0);

    // Randomised commands against the reference model
    for (int i = 0; i < 40; i++) begin
      run_cmd($sformatf("rand%0d", i), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'(i % 2), low);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
